// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches over a req/ready handshake and
// holds the fetched word for one execute window while the next PC is chosen.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  input  logic        stall,
  input  logic [1:0]  jump,
  input  logic        branch,
  input  logic        alu_zero,
  input  logic [31:0] jr_target,
  output logic [31:0] retired,
  output logic        misalign
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] retired_q, retired_d;
  logic        misalign_q, misalign_d;

  logic [31:0] pc_plus4_w;
  logic [31:0] branch_off;
  logic [31:0] next_pc;

  assign pc_plus4_w = pc_q + 32'd4;
  assign branch_off = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};

  // Jump outranks branch; the reserved jump code 11 falls through as sequential.
  always_comb begin
    next_pc = pc_plus4_w;
    case (jump)
      2'b10:   next_pc = {jr_target[31:2], 2'b00};
      2'b01:   next_pc = {pc_plus4_w[31:28], instr_q[25:0], 2'b00};
      default: begin
        if (branch && !alu_zero) begin
          next_pc = pc_plus4_w + branch_off;
        end
      end
    endcase
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    instr_d     = instr_q;
    retired_d   = retired_q;
    misalign_d  = misalign_q;
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    case (state_q)
      S_IDLE: begin
        state_d = S_FETCH;
      end
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          instr_d = imem_rdata;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        instr_valid = 1'b1;
        if (!stall) begin
          pc_d      = next_pc;
          retired_d = retired_q + 32'd1;
          if ((jump == 2'b10) && (jr_target[1:0] != 2'b00)) begin
            misalign_d = 1'b1;
          end
          state_d = S_FETCH;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      instr_q    <= 32'd0;
      retired_q  <= 32'd0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      retired_q  <= retired_d;
      misalign_q <= misalign_d;
    end
  end

  // The fetch address is the PC itself, so it cannot move while a request is open.
  assign imem_addr = pc_q;
  assign instr     = instr_q;
  assign pc        = pc_q;
  assign pc_plus4  = pc_plus4_w;
  assign retired   = retired_q;
  assign misalign  = misalign_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table, multi-cycle corner sequences and
// randomized instructions checked against a PC/retire model built from the rules.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        stall = 1'b0;
  logic [1:0]  jump = 2'b00;
  logic        branch = 1'b0;
  logic        alu_zero = 1'b0;
  logic [31:0] jr_target = 32'd0;
  logic [31:0] retired;
  logic        misalign;

  logic        w_imem_req;
  logic [31:0] w_imem_addr;
  logic [31:0] w_instr;
  logic        w_instr_valid;
  logic [31:0] w_pc;
  logic [31:0] w_pc_plus4;
  logic [31:0] w_retired;
  logic        w_misalign;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] m_pc;
  logic [31:0] m_ret;
  logic        m_mis;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .instr(instr), .instr_valid(instr_valid),
    .pc(pc), .pc_plus4(pc_plus4),
    .stall(stall), .jump(jump), .branch(branch), .alu_zero(alu_zero),
    .jr_target(jr_target), .retired(retired), .misalign(misalign)
  );

  // Second instance sitting at the top of the address space, fed by a zero-wait nop memory.
  fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk(clk), .rst_n(rst_n),
    .imem_req(w_imem_req), .imem_addr(w_imem_addr),
    .imem_ready(1'b1), .imem_rdata(32'h0000_0020),
    .instr(w_instr), .instr_valid(w_instr_valid),
    .pc(w_pc), .pc_plus4(w_pc_plus4),
    .stall(1'b0), .jump(2'b00), .branch(1'b0), .alu_zero(1'b0),
    .jr_target(32'd0), .retired(w_retired), .misalign(w_misalign)
  );

  typedef struct {
    logic [31:0] word;
    logic [1:0]  jmp;
    logic        br;
    logic        z;
    logic [31:0] jrt;
    logic [31:0] exp_pc;
    logic        exp_mis;
  } vec_t;

  vec_t tbl[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_next(input logic [31:0] cur, input logic [31:0] word,
                                           input logic [1:0] jmp, input logic br,
                                           input logic z, input logic [31:0] jrt);
    logic [31:0] p4;
    int          off;
    p4 = cur + 32'd4;
    if (jmp == 2'd2) return jrt & 32'hFFFF_FFFC;
    if (jmp == 2'd1) return (p4 & 32'hF000_0000) | ((word & 32'h03FF_FFFF) * 4);
    if (br && !z) begin
      off = int'($signed(word[15:0])) * 4;
      return p4 + off;
    end
    return p4;
  endfunction

  // One full instruction: fetch with 'waits' wait cycles, 'stalls' stalled EXEC cycles, then exit.
  task automatic do_instr(input logic [31:0] word, input int waits, input int stalls,
                          input logic [1:0] jmp, input logic br, input logic z,
                          input logic [31:0] jrt);
    int          guard;
    logic [31:0] held_ret;
    guard = 0;
    while (imem_req !== 1'b1 && guard < 5) begin
      @(negedge clk);
      guard++;
    end
    if (imem_req !== 1'b1) begin
      check("fetch_start_timeout", {31'd0, imem_req}, 32'd1);
      return;
    end
    for (int k = 0; k <= waits; k++) begin
      check("fetch_addr", imem_addr, m_pc);
      imem_ready = (k == waits);
      imem_rdata = (k == waits) ? word : $urandom;
      @(negedge clk);
    end
    imem_ready = 1'b0;
    check("exec_valid", {31'd0, instr_valid}, 32'd1);
    check("exec_req", {31'd0, imem_req}, 32'd0);
    check("exec_instr", instr, word);
    check("exec_pc", pc, m_pc);
    check("exec_pc_plus4", pc_plus4, m_pc + 32'd4);
    held_ret = retired;
    jump = jmp; branch = br; alu_zero = z; jr_target = jrt;
    for (int s = 0; s <= stalls; s++) begin
      stall = (s < stalls);
      imem_ready = (s < stalls);
      imem_rdata = $urandom;
      @(negedge clk);
      if (s < stalls) begin
        check("stall_pc", pc, m_pc);
        check("stall_instr", instr, word);
        check("stall_retired", retired, held_ret);
        check("stall_valid", {31'd0, instr_valid}, 32'd1);
      end
    end
    stall = 1'b0; imem_ready = 1'b0;
    m_pc  = ref_next(m_pc, word, jmp, br, z, jrt);
    m_ret = m_ret + 32'd1;
    if (jmp == 2'd2 && jrt[1:0] != 2'b00) m_mis = 1'b1;
    jump = 2'b00; branch = 1'b0; alu_zero = 1'b0; jr_target = 32'd0;
    check("exit_pc", pc, m_pc);
    check("exit_retired", retired, m_ret);
    check("exit_misalign", {31'd0, misalign}, {31'd0, m_mis});
    check("exit_valid", {31'd0, instr_valid}, 32'd0);
    $display("instr %h jmp=%0d br=%0d z=%0d -> pc %h retired %0d", word, jmp, br, z, pc, retired);
  endtask

  initial begin
    tbl[0] = '{32'h0800_0040, 2'd1, 1'b0, 1'b0, 32'd0,        32'h0000_0100, 1'b0};
    tbl[1] = '{32'h1420_FFFF, 2'd0, 1'b1, 1'b0, 32'd0,        32'h0000_0100, 1'b0};
    tbl[2] = '{32'h1420_FFFF, 2'd0, 1'b1, 1'b1, 32'd0,        32'h0000_0104, 1'b0};
    tbl[3] = '{32'h0800_0040, 2'd1, 1'b1, 1'b0, 32'd0,        32'h0000_0100, 1'b0};
    tbl[4] = '{32'h0020_0008, 2'd2, 1'b0, 1'b0, 32'h0000_2007, 32'h0000_2004, 1'b1};
    tbl[5] = '{32'h0000_0020, 2'd0, 1'b0, 1'b0, 32'd0,        32'h0000_2008, 1'b1};
    tbl[6] = '{32'h0000_0020, 2'd3, 1'b0, 1'b0, 32'd0,        32'h0000_200C, 1'b1};
    tbl[7] = '{32'h1420_0002, 2'd3, 1'b1, 1'b0, 32'd0,        32'h0000_2018, 1'b1};

    m_pc = 32'd0; m_ret = 32'd0; m_mis = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_req", {31'd0, imem_req}, 32'd0);
    check("rst_addr", imem_addr, 32'd0);
    check("rst_instr", instr, 32'd0);
    check("rst_valid", {31'd0, instr_valid}, 32'd0);
    check("rst_pc", pc, 32'd0);
    check("rst_retired", retired, 32'd0);
    check("rst_misalign", {31'd0, misalign}, 32'd0);
    check("rst_wrap_addr", w_imem_addr, 32'hFFFF_FFFC);
    rst_n = 1'b1;
    @(negedge clk);
    check("first_fetch_req", {31'd0, imem_req}, 32'd1);
    check("wrap_fetch_addr", w_imem_addr, 32'hFFFF_FFFC);
    check("wrap_pc_plus4", w_pc_plus4, 32'd0);
    repeat (2) @(negedge clk);
    check("wrap_next_addr", w_imem_addr, 32'd0);
    check("wrap_next_req", {31'd0, w_imem_req}, 32'd1);
    check("wrap_retired", w_retired, 32'd1);

    // Sequential zero-wait adds at 0, 4, 8.
    for (int i = 0; i < 3; i++) do_instr(32'h0000_0020, 0, 0, 2'd0, 1'b0, 1'b0, 32'd0);
    check("seq_retired", retired, 32'd3);
    // Three wait states then two stalled EXEC cycles.
    do_instr(32'h0000_0020, 3, 2, 2'd0, 1'b0, 1'b0, 32'd0);

    for (int i = 0; i < 8; i++) begin
      do_instr(tbl[i].word, i % 3, 0, tbl[i].jmp, tbl[i].br, tbl[i].z, tbl[i].jrt);
      check("tbl_pc", pc, tbl[i].exp_pc);
      check("tbl_misalign", {31'd0, misalign}, {31'd0, tbl[i].exp_mis});
    end

    for (int i = 0; i < 40; i++) begin
      do_instr($urandom, int'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
               2'($urandom_range(0, 3)), 1'($urandom), 1'($urandom), $urandom);
    end

    // Asynchronous reset while a request is open, then a late ready.
    @(negedge clk);
    check("pre_rst_req", {31'd0, imem_req}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_req", {31'd0, imem_req}, 32'd0);
    check("async_valid", {31'd0, instr_valid}, 32'd0);
    check("async_pc", pc, 32'd0);
    check("async_misalign", {31'd0, misalign}, 32'd0);
    imem_ready = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    check("late_ready_instr", instr, 32'd0);
    imem_ready = 1'b0;
    rst_n = 1'b1;
    m_pc = 32'd0; m_ret = 32'd0; m_mis = 1'b0;
    @(negedge clk);
    do_instr(32'h0000_0020, 1, 0, 2'd0, 1'b0, 1'b0, 32'd0);
    do_instr(32'h0000_0020, 0, 1, 2'd0, 1'b0, 1'b0, 32'd0);
    check("restart_pc", pc, 32'd8);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the single-cycle MIPS core; sits directly upstream of the main control decoder. Holds the program counter, fetches each instruction from instruction memory over a request/ready handshake, and presents the latched instruction (opcode `[31:26]`, funct `[5:0]`) to the decoder and datapath for one execute window. Computes the next PC from the decoder's `Jump`/`Branch` outputs, the ALU zero flag and the `jr` register value.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset; low two bits must be 0.
- `clk` in 1: single clock, all state on rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `imem_req` out 1: fetch request.
- `imem_addr` out 32: byte address of the word being fetched.
- `imem_ready` in 1: `imem_rdata` valid this cycle; meaningful only while `imem_req`=1.
- `imem_rdata` in 32: fetched instruction word.
- `instr` out 32: latched instruction, stable from FETCH completion until the next capture.
- `instr_valid` out 1: high for the whole EXEC state.
- `pc` out 32: address of `instr`.
- `pc_plus4` out 32: `pc`+4 mod 2^32, the link value for `jal`.
- `stall` in 1: hold in EXEC; no PC update.
- `jump` in 2: decoder `Jump`. 00 = sequential, 01 = `j`/`jal`, 10 = `jr`, 11 = treated as 00.
- `branch` in 1: decoder `Branch` (`bne`).
- `alu_zero` in 1: ALU zero flag.
- `jr_target` in 32: rs register value for `jr`.
- `retired` out 32: count of completed EXEC windows, wraps.
- `misalign` out 1: sticky flag, set when a `jr` target has nonzero `[1:0]`.

## Operation
- States: IDLE, FETCH, EXEC.
- IDLE: entered on reset and lasts one cycle. Outputs are quiet. Always goes to FETCH.
- FETCH:
  - `imem_req`=1 and `imem_addr`=`pc`; both are held stable until `imem_ready`.
  - On `imem_ready`=1: capture `imem_rdata` into `instr`, then go to EXEC.
- EXEC: `instr_valid`=1.
  - If `stall`=1: stay in EXEC; `pc`, `instr` and `retired` are held.
  - If `stall`=0: `pc` <= `next_pc`, `retired` += 1, then go to FETCH.
- `next_pc` is evaluated in the EXEC cycle. Jump has priority over branch.
  - `jump`=10: `{jr_target[31:2],2'b00}`. If `jr_target[1:0]`≠0, set `misalign`.
  - `jump`=01: `{pc_plus4[31:28], instr[25:0], 2'b00}`.
  - Otherwise, `branch`=1 and `alu_zero`=0 (bne taken): `pc_plus4 + {{14{instr[15]}}, instr[15:0], 2'b00}`, mod 2^32.
  - Otherwise: `pc_plus4`.
- Arithmetic is 32-bit unsigned with wrap. `32'hFFFF_FFFC`+4 = 0.
- `imem_ready` outside FETCH is ignored.
- `misalign` is cleared only by reset.
- Reset values: state IDLE, `pc`=`RESET_PC`, `instr`=0, `instr_valid`=0, `imem_req`=0, `imem_addr`=`RESET_PC`, `retired`=0, `misalign`=0.
- Reset asserted mid-operation: everything returns to the reset values immediately (asynchronous). Any outstanding memory response is dropped; the memory must tolerate a request withdrawn without `imem_ready`.

## Timing
- `rst_n` rises at edge 0. Edge 0→1 is IDLE. FETCH starts in cycle 1 with `imem_req`=1 and `imem_addr`=`RESET_PC`.
- Zero-wait memory (`imem_ready` in the first FETCH cycle): EXEC in the next cycle. Minimum cost is 2 cycles per instruction.
- N wait cycles add N cycles to the fetch.
- `instr_valid` rises in the cycle after `imem_ready` is sampled. It falls on the edge where `stall`=0 is sampled.
- The decoder is combinational from `instr`. `jump`, `branch`, `alu_zero` and `jr_target` must be settled before the EXEC clock edge.
- `pc` and `pc_plus4` are registered and change only on an EXEC exit edge or on reset.

## Test plan
- Reset and sequential fetch: zero-wait memory returns `add` (funct 100000) at 0, 4, 8. Required: `imem_addr` reads 0, 4, 8; `instr_valid` alternates 0/1; `retired`=3 after 6 cycles.
- Wait states plus stall:
  - Hold `imem_ready` low for 3 cycles. Required: `imem_addr` stable across all 4 FETCH cycles.
  - Then `stall`=1 for 2 EXEC cycles. Required: `pc`, `instr` and `retired` unchanged; PC advances only after `stall` drops.
- Control flow at `pc`=0x100:
  - `bne` with imm=0xFFFF, `alu_zero`=0. Required: next `pc`=0x100.
  - Same with `alu_zero`=1. Required: next `pc`=0x104.
  - `j` with target 0x40 while `branch`=1. Required: `pc`=0x100; jump wins.
- `jr`: `jr_target`=0x2007. Required: next `pc`=0x2004, `misalign`=1; it stays 1 over later instructions until `rst_n` pulses.
- Wrap:
  - `RESET_PC`=0xFFFF_FFFC with a sequential instruction. Required: next `imem_addr`=0, `pc_plus4` was 0.
  - Preload `retired`=0xFFFF_FFFF by running the sequence. Required: wraps to 0.
- Async reset mid-FETCH: drop `rst_n` with `imem_req`=1 and no clock edge. Required: `imem_req`=0, `instr_valid`=0, `pc`=`RESET_PC` immediately; a late `imem_ready` does not change `instr`.
